// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply / divide sequencer for the EX stage.
// Holds the pipeline via stall while a WIDTH-iteration shift-add or restoring divide runs.
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       funct_code,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_by_zero
);

   localparam int unsigned CW        = $clog2(WIDTH + 1);
   localparam logic [3:0]  FUNCT_MUL = 4'b0100;
   localparam logic [3:0]  FUNCT_DIV = 4'b1000;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [CW-1:0]        count;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_step;
   logic [WIDTH-1:0]     opnd;
   logic                 sign_a;
   logic                 sign_b;
   logic                 is_div;

   logic                 mul_req;
   logic                 div_req;
   logic                 accept;
   logic                 div_zero_req;
   logic                 last_iter;
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       part;
   logic [WIDTH:0]       diff;
   logic [WIDTH-1:0]     quo_mag;
   logic [WIDTH-1:0]     rem_mag;
   logic [WIDTH-1:0]     quo_signed;
   logic [WIDTH-1:0]     rem_signed;
   logic [2*WIDTH-1:0]   prod_signed;

   always_comb begin
      mul_req      = (funct_code == FUNCT_MUL);
      div_req      = (funct_code == FUNCT_DIV);
      accept       = (state == IDLE) & start & (mul_req | div_req) & ~flush;
      div_zero_req = div_req & (op_b == '0);
      last_iter    = (count == CW'(1));
      mag_a        = op_a[WIDTH-1] ? -op_a : op_a;
      mag_b        = op_b[WIDTH-1] ? -op_b : op_b;
   end

   // One iteration: acc holds {partial product, multiplier} for multiply and
   // {remainder, dividend/quotient} for divide; opnd is the other magnitude.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      part     = acc[2*WIDTH-1:WIDTH-1];
      diff     = part - {1'b0, opnd};
      acc_step = '0;
      if (is_div) begin
         if (!diff[WIDTH])
            acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_step = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   always_comb begin
      quo_mag     = acc_step[WIDTH-1:0];
      rem_mag     = acc_step[2*WIDTH-1:WIDTH];
      prod_signed = (sign_a ^ sign_b) ? -acc_step : acc_step;
      quo_signed  = (sign_a ^ sign_b) ? -quo_mag : quo_mag;
      rem_signed  = sign_a ? -rem_mag : rem_mag;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept)
               state_next = div_zero_req ? DONE : RUN;
         end
         RUN: begin
            if (flush)
               state_next = IDLE;
            else if (last_iter)
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      stall = (state == RUN) | accept;
      busy  = (state == RUN) | (state == DONE);
      done  = (state == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         count       <= '0;
         acc         <= '0;
         opnd        <= '0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         is_div      <= 1'b0;
         result_lo   <= '0;
         result_hi   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (accept) begin
                  sign_a      <= op_a[WIDTH-1];
                  sign_b      <= op_b[WIDTH-1];
                  is_div      <= div_req;
                  count       <= CW'(WIDTH);
                  div_by_zero <= 1'b0;
                  if (div_req) begin
                     acc  <= {{WIDTH{1'b0}}, mag_a};
                     opnd <= mag_b;
                  end else begin
                     acc  <= {{WIDTH{1'b0}}, mag_b};
                     opnd <= mag_a;
                  end
                  // Divide by zero bypasses RUN, so its results land here.
                  if (div_zero_req) begin
                     result_lo   <= '1;
                     result_hi   <= op_a;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (!flush) begin
                  acc   <= acc_step;
                  count <= count - CW'(1);
                  if (last_iter) begin
                     if (is_div) begin
                        result_lo <= quo_signed;
                        result_hi <= rem_signed;
                     end else begin
                        result_lo <= prod_signed[WIDTH-1:0];
                        result_hi <= prod_signed[2*WIDTH-1:WIDTH];
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results are queued at issue
// and popped when done pulses.
module tb_muldiv_sequencer;

   localparam int unsigned W     = 16;
   localparam logic [3:0]  F_MUL = 4'b0100;
   localparam logic [3:0]  F_DIV = 4'b1000;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [3:0]   funct_code = '0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         stall;
   logic         busy;
   logic         done;
   logic [W-1:0] result_lo;
   logic [W-1:0] result_hi;
   logic         div_by_zero;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] lo;
      logic [15:0] hi;
      logic        dbz;
      int          lat;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .funct_code  (funct_code),
      .op_a        (op_a),
      .op_b        (op_b),
      .flush       (flush),
      .stall       (stall),
      .busy        (busy),
      .done        (done),
      .result_lo   (result_lo),
      .result_hi   (result_hi),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int   sa;
      int   sbv;
      int   p;
      int   q;
      int   r;
      sa  = $signed(a);
      sbv = $signed(b);
      e.dbz = 1'b0;
      e.lat = 17;
      if (f == F_MUL) begin
         p    = sa * sbv;
         e.lo = p[15:0];
         e.hi = p[31:16];
      end else if (b == 16'h0000) begin
         e.lo  = 16'hFFFF;
         e.hi  = a;
         e.dbz = 1'b1;
         e.lat = 1;
      end else begin
         q    = sa / sbv;
         r    = sa % sbv;
         e.lo = q[15:0];
         e.hi = r[15:0];
      end
      return e;
   endfunction

   // Drive a request for cycle 0 (called #1 after a rising edge).
   task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      funct_code = f;
      op_a       = a;
      op_b       = b;
      start      = 1'b1;
      sb.push_back(model(f, a, b));
   endtask

   // Observe cycles 0..budget-1 on falling edges; optionally re-pulse start or flush.
   task automatic wait_done(input int budget, input int repulse, input int flush_at,
                            output logic seen, output int lat, output int stall_cnt,
                            output logic busy_done);
      seen      = 1'b0;
      lat       = -1;
      stall_cnt = 0;
      busy_done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (stall === 1'b1) stall_cnt++;
         if (done === 1'b1) begin
            seen      = 1'b1;
            lat       = c;
            busy_done = busy;
            break;
         end
         @(posedge clk);
         #1;
         start = (c + 1 == repulse);
         flush = (c + 1 == flush_at);
      end
      start = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({stall, busy, done, div_by_zero} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0000", {stall, busy, done, div_by_zero});
      end
      checks++;
      if ({result_hi, result_lo} !== 32'h0) begin
         errors++;
         $display("FAIL reset_result: got %h expected 00000000", {result_hi, result_lo});
      end
      reset_n = 1'b1;
   endtask

   task automatic test_mult();
      logic [15:0] ta[4] = '{16'h0007, 16'h8000, 16'hFFF6, 16'h7FFF};
      logic [15:0] tb[4] = '{16'hFFFD, 16'h8000, 16'hFFF4, 16'h7FFF};
      logic seen, bd;
      int   lat, sc;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         issue(F_MUL, ta[i], tb[i]);
         wait_done(40, -1, -1, seen, lat, sc, bd);
         e = sb.pop_front();
         checks++;
         if (!seen || lat != e.lat) begin
            errors++;
            $display("FAIL mult_latency[%0d]: got %0d expected %0d", i, lat, e.lat);
         end
         checks++;
         if (sc != e.lat) begin
            errors++;
            $display("FAIL mult_stall_cycles[%0d]: got %0d expected %0d", i, sc, e.lat);
         end
         checks++;
         if ({result_hi, result_lo} !== {e.hi, e.lo}) begin
            errors++;
            $display("FAIL mult_result[%0d]: got %h expected %h", i, {result_hi, result_lo}, {e.hi, e.lo});
         end
         checks++;
         if (bd !== 1'b1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL mult_flags[%0d]: got busy=%b dbz=%b expected busy=1 dbz=0", i, bd, div_by_zero);
         end
         last_exp = e;
      end
   endtask

   task automatic test_div();
      logic [15:0] ta[5] = '{16'd100, 16'hFF9C, 16'd100, 16'h8000, 16'd5};
      logic [15:0] tb[5] = '{16'd7,   16'd7,   16'hFFF9, 16'hFFFF, 16'd9};
      logic seen, bd;
      int   lat, sc;
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         issue(F_DIV, ta[i], tb[i]);
         wait_done(40, -1, -1, seen, lat, sc, bd);
         e = sb.pop_front();
         checks++;
         if (!seen || lat != e.lat) begin
            errors++;
            $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lat, e.lat);
         end
         checks++;
         if ({result_hi, result_lo} !== {e.hi, e.lo}) begin
            errors++;
            $display("FAIL div_result[%0d]: got %h expected %h", i, {result_hi, result_lo}, {e.hi, e.lo});
         end
         checks++;
         if (div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL div_dbz[%0d]: got %b expected 0", i, div_by_zero);
         end
         last_exp = e;
      end
   endtask

   task automatic test_div_by_zero();
      logic seen, bd;
      int   lat, sc;
      exp_t e;
      @(posedge clk); #1;
      issue(F_DIV, 16'h1234, 16'h0000);
      wait_done(40, -1, -1, seen, lat, sc, bd);
      e = sb.pop_front();
      checks++;
      if (!seen || lat != e.lat) begin
         errors++;
         $display("FAIL dbz_latency: got %0d expected %0d", lat, e.lat);
      end
      checks++;
      if (sc != 1) begin
         errors++;
         $display("FAIL dbz_stall_cycles: got %0d expected 1", sc);
      end
      checks++;
      if ({div_by_zero, result_hi, result_lo} !== {e.dbz, e.hi, e.lo}) begin
         errors++;
         $display("FAIL dbz_result: got %h expected %h", {div_by_zero, result_hi, result_lo}, {e.dbz, e.hi, e.lo});
      end
      // The flag must clear on the following accepted operation.
      @(posedge clk); #1;
      issue(F_MUL, 16'd2, 16'd3);
      wait_done(40, -1, -1, seen, lat, sc, bd);
      e = sb.pop_front();
      checks++;
      if (!seen || div_by_zero !== 1'b0 || {result_hi, result_lo} !== {e.hi, e.lo}) begin
         errors++;
         $display("FAIL dbz_clear: got seen=%b dbz=%b res=%h expected seen=1 dbz=0 res=%h",
                  seen, div_by_zero, {result_hi, result_lo}, {e.hi, e.lo});
      end
      last_exp = e;
   endtask

   task automatic test_illegal_funct();
      logic seen, bd;
      int   lat, sc;
      @(posedge clk); #1;
      funct_code = 4'b0000;
      op_a       = 16'd9;
      op_b       = 16'd9;
      start      = 1'b1;
      wait_done(6, -1, -1, seen, lat, sc, bd);
      checks++;
      if (seen || sc != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL illegal_funct: got seen=%b stall_cycles=%0d busy=%b expected 0 0 0", seen, sc, busy);
      end
      @(posedge clk); #1;
      funct_code = F_MUL;
      start      = 1'b1;
      flush      = 1'b1;
      wait_done(6, -1, -1, seen, lat, sc, bd);
      checks++;
      if (seen || sc != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_with_flush: got seen=%b stall_cycles=%0d busy=%b expected 0 0 0", seen, sc, busy);
      end
   endtask

   task automatic test_restart_ignored();
      logic seen, bd;
      int   lat, sc;
      exp_t e;
      @(posedge clk); #1;
      issue(F_MUL, 16'd300, 16'hFFD3);
      wait_done(40, 5, -1, seen, lat, sc, bd);
      e = sb.pop_front();
      checks++;
      if (!seen || lat != 17 || {result_hi, result_lo} !== {e.hi, e.lo}) begin
         errors++;
         $display("FAIL restart_ignored: got lat=%0d res=%h expected lat=17 res=%h", lat, {result_hi, result_lo}, {e.hi, e.lo});
      end
      last_exp = e;
      @(posedge clk); #1;
      wait_done(25, -1, -1, seen, lat, sc, bd);
      checks++;
      if (seen || sc != 0) begin
         errors++;
         $display("FAIL restart_no_queue: got seen=%b stall_cycles=%0d expected 0 0", seen, sc);
      end
   endtask

   task automatic test_flush();
      logic seen, bd;
      int   lat, sc;
      @(posedge clk); #1;
      issue(F_MUL, 16'd123, 16'd456);
      void'(sb.pop_back());
      wait_done(30, -1, 8, seen, lat, sc, bd);
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL flush_no_done: got done at cycle %0d expected none", lat);
      end
      checks++;
      if (sc != 9) begin
         errors++;
         $display("FAIL flush_stall_cycles: got %0d expected 9", sc);
      end
      checks++;
      if ({result_hi, result_lo} !== {last_exp.hi, last_exp.lo} || busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_results_held: got res=%h busy=%b expected res=%h busy=0",
                  {result_hi, result_lo}, busy, {last_exp.hi, last_exp.lo});
      end
   endtask

   task automatic test_reset_mid_op();
      logic seen, bd;
      int   lat, sc;
      exp_t e;
      @(posedge clk); #1;
      issue(F_DIV, 16'hFC18, 16'd7);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset_n = 1'b0;
      sb.delete();
      #1;
      checks++;
      if ({stall, busy, done, div_by_zero, result_hi, result_lo} !== 36'h0) begin
         errors++;
         $display("FAIL reset_mid_op: got %h expected 000000000",
                  {stall, busy, done, div_by_zero, result_hi, result_lo});
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      issue(F_MUL, 16'hFF00, 16'd77);
      wait_done(40, -1, -1, seen, lat, sc, bd);
      e = sb.pop_front();
      checks++;
      if (!seen || lat != 17 || {result_hi, result_lo} !== {e.hi, e.lo}) begin
         errors++;
         $display("FAIL after_reset_mult: got lat=%0d res=%h expected lat=17 res=%h", lat, {result_hi, result_lo}, {e.hi, e.lo});
      end
      last_exp = e;
   endtask

   task automatic test_back_to_back();
      logic        seen, bd;
      int          lat, sc;
      exp_t        e;
      logic [3:0]  f;
      logic [15:0] a;
      logic [15:0] b;
      for (int i = 0; i < 8; i++) begin
         f = ($urandom_range(1) == 0) ? F_MUL : F_DIV;
         a = 16'($urandom);
         b = (i == 3) ? 16'h0000 : 16'($urandom);
         @(posedge clk); #1;
         issue(f, a, b);
         wait_done(40, -1, -1, seen, lat, sc, bd);
         e = sb.pop_front();
         checks++;
         if (!seen || lat != e.lat || {div_by_zero, result_hi, result_lo} !== {e.dbz, e.hi, e.lo}) begin
            errors++;
            $display("FAIL b2b[%0d] f=%b a=%h b=%h: got lat=%0d res=%h expected lat=%0d res=%h",
                     i, f, a, b, lat, {div_by_zero, result_hi, result_lo}, e.lat, {e.dbz, e.hi, e.lo});
         end
         last_exp = e;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_by_zero();
      test_illegal_funct();
      test_restart_ignored();
      test_flush();
      test_reset_mid_op();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
